// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Multi-channel status-LED pattern engine. Every channel plays its own on/off
// bit pattern at a shared bit rate. Each channel has its own length, loop or
// one-shot mode, PWM brightness and start/stop control.
// Each channel keeps a shadow copy of its configuration, written at any time,
// and an active copy that is loaded only when the channel accepts a start.
// A running pattern is therefore never disturbed by configuration traffic.
module led_pattern_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int PATTERN_LEN = 32,
  parameter int STEP_DIV    = 2097152,
  parameter int PWM_W       = 4
) (
  input  logic                                              CLK_CPU,
  input  logic                                              reset,
  input  logic                                              cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [PATTERN_LEN-1:0]                            cfg_pattern,
  input  logic [$clog2(PATTERN_LEN):0]                      cfg_len,
  input  logic                                              cfg_loop,
  input  logic [PWM_W-1:0]                                  cfg_bright,
  input  logic [CHANNELS-1:0]                               start,
  input  logic [CHANNELS-1:0]                               stop,
  output logic [CHANNELS-1:0]                               led,
  output logic [CHANNELS-1:0]                               busy,
  output logic [CHANNELS-1:0]                               done
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LEN_W = $clog2(PATTERN_LEN) + 1;
  localparam int IDX_W = $clog2(PATTERN_LEN);
  localparam int PS_W  = $clog2(STEP_DIV);

  localparam logic [CH_W:0]      CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [LEN_W-1:0]   MAX_LEN  = LEN_W'(PATTERN_LEN);
  localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(STEP_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Lengths beyond the pattern width would index past the pattern, so they
  // are limited to the full pattern width when captured.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  // Full brightness must be solidly on, not on for all but one PWM slot.
  function automatic logic pwm_on(input logic [PWM_W-1:0] cnt,
                                  input logic [PWM_W-1:0] bright);
    return (cnt < bright) || (&bright);
  endfunction

  // ---------------------------------------------------------------------------
  // Shared timing: bit-rate prescaler and PWM counter
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0]  presc_reg;
  logic [PS_W-1:0]  presc_next;
  logic             tick;
  logic [PWM_W-1:0] pwm_cnt_reg;
  logic [PWM_W-1:0] pwm_cnt_next;

  // Prescaler wraps at STEP_DIV-1 and flags the step; PWM counter free-runs.
  always_comb begin
    tick         = (presc_reg == PS_LAST);
    presc_next   = tick ? '0 : presc_reg + PS_W'(1);
    pwm_cnt_next = pwm_cnt_reg + PWM_W'(1);
  end

  // Shared counters are free-running; starts never realign them.
  always_ff @(posedge CLK_CPU) begin
    if (reset) begin
      presc_reg   <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      presc_reg   <= presc_next;
      pwm_cnt_reg <= pwm_cnt_next;
    end
  end

  // Writes addressed beyond the last channel are dropped.
  logic cfg_ch_ok;
  assign cfg_ch_ok = ({1'b0, cfg_ch} < CH_LIMIT);

  // ---------------------------------------------------------------------------
  // Per-channel engines
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic                   wr_sel;

      logic [PATTERN_LEN-1:0] sh_pattern_reg;
      logic [LEN_W-1:0]       sh_len_reg;
      logic                   sh_loop_reg;
      logic [PWM_W-1:0]       sh_bright_reg;

      logic [PATTERN_LEN-1:0] act_pattern_reg;
      logic [PATTERN_LEN-1:0] act_pattern_next;
      logic [LEN_W-1:0]       act_len_reg;
      logic [LEN_W-1:0]       act_len_next;
      logic                   act_loop_reg;
      logic                   act_loop_next;
      logic [PWM_W-1:0]       act_bright_reg;
      logic [PWM_W-1:0]       act_bright_next;

      logic [IDX_W-1:0]       idx_reg;
      logic [IDX_W-1:0]       idx_next;
      logic [LEN_W-1:0]       last_idx;
      state_t                 state_reg;
      state_t                 state_next;

      logic                   led_reg;
      logic                   led_next;
      logic                   done_reg;
      logic                   done_next;

      assign wr_sel = cfg_we && cfg_ch_ok && (cfg_ch == CH_W'(gi));

      // Shadow configuration: captured on every write to this channel.
      always_ff @(posedge CLK_CPU) begin
        if (reset) begin
          sh_pattern_reg <= '0;
          sh_len_reg     <= '0;
          sh_loop_reg    <= 1'b0;
          sh_bright_reg  <= '0;
        end else if (wr_sel) begin
          sh_pattern_reg <= cfg_pattern;
          sh_len_reg     <= clamp_len(cfg_len);
          sh_loop_reg    <= cfg_loop;
          sh_bright_reg  <= cfg_bright;
        end
      end

      // Active length is 1..PATTERN_LEN while running, so len-1 never wraps.
      assign last_idx = act_len_reg - LEN_W'(1);

      // Next-state logic: stop beats start, and start beats the step tick.
      always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        act_pattern_next = act_pattern_reg;
        act_len_next     = act_len_reg;
        act_loop_next    = act_loop_reg;
        act_bright_next  = act_bright_reg;
        done_next        = 1'b0;

        if (stop[gi]) begin
          state_next = ST_IDLE;
        end else if (start[gi]) begin
          if (sh_len_reg != '0) begin
            act_pattern_next = sh_pattern_reg;
            act_len_next     = sh_len_reg;
            act_loop_next    = sh_loop_reg;
            act_bright_next  = sh_bright_reg;
            idx_next         = '0;
            state_next       = ST_RUN;
          end else begin
            // An empty shadow disables the channel, even mid-run.
            state_next = ST_IDLE;
          end
        end else if ((state_reg == ST_RUN) && tick) begin
          if (LEN_W'(idx_reg) != last_idx) begin
            idx_next = idx_reg + IDX_W'(1);
          end else if (act_loop_reg) begin
            idx_next = '0;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end

        // Drive is computed from the post-edge state and PWM phase so the
        // registered output matches the state registers cycle for cycle.
        led_next = (state_next == ST_RUN) && act_pattern_next[idx_next] &&
                   pwm_on(pwm_cnt_next, act_bright_next);
      end

      // State, active configuration and registered outputs.
      always_ff @(posedge CLK_CPU) begin
        if (reset) begin
          state_reg       <= ST_IDLE;
          idx_reg         <= '0;
          act_pattern_reg <= '0;
          act_len_reg     <= '0;
          act_loop_reg    <= 1'b0;
          act_bright_reg  <= '0;
          led_reg         <= 1'b0;
          done_reg        <= 1'b0;
        end else begin
          state_reg       <= state_next;
          idx_reg         <= idx_next;
          act_pattern_reg <= act_pattern_next;
          act_len_reg     <= act_len_next;
          act_loop_reg    <= act_loop_next;
          act_bright_reg  <= act_bright_next;
          led_reg         <= led_next;
          done_reg        <= done_next;
        end
      end

      assign led[gi]  = led_reg;
      assign busy[gi] = (state_reg == ST_RUN);
      assign done[gi] = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (2 channels, 8-bit patterns,
// 4-cycle bit period, 2-bit PWM).
module tb_led_pattern_sequencer;

  localparam int CH = 2;
  localparam int PL = 8;
  localparam int SD = 4;
  localparam int PW = 2;
  localparam int PWM_MOD = 1 << PW;
  localparam int BRIGHT_MAX = PWM_MOD - 1;

  logic       CLK_CPU = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_loop = 1'b0;
  logic [1:0] cfg_bright = '0;
  logic [1:0] start = '0;
  logic [1:0] stop = '0;
  logic [1:0] led;
  logic [1:0] busy;
  logic [1:0] done;

  int n_assert = 0;
  int n_fail = 0;

  led_pattern_sequencer #(
    .CHANNELS(CH), .PATTERN_LEN(PL), .STEP_DIV(SD), .PWM_W(PW)
  ) dut (
    .CLK_CPU(CLK_CPU), .reset(reset),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_loop(cfg_loop), .cfg_bright(cfg_bright),
    .start(start), .stop(stop),
    .led(led), .busy(busy), .done(done)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  // Reference model: per-channel player described by position in the
  // pattern and a cycle count since reset (bit clock and PWM phase derive
  // from that count arithmetically).
  logic [7:0] sh_pat [CH];
  int         sh_len [CH];
  bit         sh_loop[CH];
  int         sh_bri [CH];
  logic [7:0] a_pat  [CH];
  int         a_len  [CH];
  bit         a_loop [CH];
  int         a_bri  [CH];
  bit         m_run  [CH];
  int         m_pos  [CH];
  bit         m_done [CH];
  int         m_cnt = 0;

  task automatic model_edge();
    bit step;
    if (reset) begin
      m_cnt = 0;
      for (int c = 0; c < CH; c++) begin
        sh_pat[c] = '0; sh_len[c] = 0; sh_loop[c] = 0; sh_bri[c] = 0;
        a_pat[c] = '0; a_len[c] = 0; a_loop[c] = 0; a_bri[c] = 0;
        m_run[c] = 0; m_pos[c] = 0; m_done[c] = 0;
      end
    end else begin
      step = ((m_cnt % SD) == SD - 1);
      m_cnt++;
      for (int c = 0; c < CH; c++) begin
        m_done[c] = 0;
        if (stop[c]) begin
          m_run[c] = 0;
        end else if (start[c]) begin
          if (sh_len[c] != 0) begin
            a_pat[c] = sh_pat[c]; a_len[c] = sh_len[c];
            a_loop[c] = sh_loop[c]; a_bri[c] = sh_bri[c];
            m_pos[c] = 0; m_run[c] = 1;
          end else begin
            m_run[c] = 0;
          end
        end else if (m_run[c] && step) begin
          if (m_pos[c] + 1 < a_len[c]) m_pos[c]++;
          else if (a_loop[c]) m_pos[c] = 0;
          else begin m_run[c] = 0; m_done[c] = 1; end
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          sh_pat[c] = cfg_pattern; sh_len[c] = int'(cfg_len);
          sh_loop[c] = cfg_loop; sh_bri[c] = int'(cfg_bright);
        end
      end
    end
  endtask

  function automatic int exp_led(int c);
    int phase;
    phase = m_cnt % PWM_MOD;
    return (m_run[c] && a_pat[c][m_pos[c]] &&
            (phase < a_bri[c] || a_bri[c] == BRIGHT_MAX)) ? 1 : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already driven, model advanced at the edge, outputs
  // compared 1 ns later, single-cycle strobes then released.
  task automatic cyc();
    @(posedge CLK_CPU);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("model_led[%0d]", c), int'(led[c]), exp_led(c));
      check($sformatf("model_busy[%0d]", c), int'(busy[c]), int'(m_run[c]));
      check($sformatf("model_done[%0d]", c), int'(done[c]), int'(m_done[c]));
    end
    $display("cyc t=%0t rst=%0b start=%b stop=%b we=%0b led=%b busy=%b done=%b",
             $time, reset, start, stop, cfg_we, led, busy, done);
    cfg_we = 1'b0;
    start  = '0;
    stop   = '0;
  endtask

  task automatic write_cfg(int ch, logic [7:0] pat, int len, bit lp, int bri);
    cfg_we = 1'b1; cfg_ch = ch[0:0]; cfg_pattern = pat;
    cfg_len = len[3:0]; cfg_loop = lp; cfg_bright = bri[1:0];
  endtask

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       lp;
    logic [1:0] bri;
    logic [1:0] st;
    logic [1:0] exp_led;
    logic [1:0] exp_busy;
    logic [1:0] exp_done;
  } vec_t;

  function automatic vec_t mk(logic we, logic [7:0] pat, logic [3:0] len, logic lp,
                              logic [1:0] bri, logic [1:0] st,
                              logic [1:0] el, logic [1:0] eb, logic [1:0] ed);
    vec_t v;
    v.we = we; v.pat = pat; v.len = len; v.lp = lp; v.bri = bri; v.st = st;
    v.exp_led = el; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  vec_t vt[13];

  initial begin
    int cnt;
    logic [7:0] hold;

    // One-shot 1,0,1 on channel 0, applied from a fresh reset so the bit
    // clock phase is known: steps land on every 4th edge after reset.
    vt[0]  = mk(1, 8'b0000_0101, 3, 0, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    vt[1]  = mk(0, 8'h00, 0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b00);
    vt[2]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    vt[3]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    vt[4]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    vt[5]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    vt[6]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    vt[7]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    vt[8]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    vt[9]  = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    vt[10] = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    vt[11] = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01);
    vt[12] = mk(0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset, idle, and a start with an empty configuration.
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_outputs", int'({led, busy, done}), 0);
    end
    start = 2'b01;
    cyc();
    check("start_len0_busy", int'(busy), 0);

    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (vt[i].we) write_cfg(0, vt[i].pat, int'(vt[i].len), vt[i].lp, int'(vt[i].bri));
      start = vt[i].st;
      cyc();
      check($sformatf("tbl%0d_led", i), int'(led), int'(vt[i].exp_led));
      check($sformatf("tbl%0d_busy", i), int'(busy), int'(vt[i].exp_busy));
      check($sformatf("tbl%0d_done", i), int'(done), int'(vt[i].exp_done));
    end

    // Channel 1 looped, quarter brightness: lit 1 of every 4 cycles.
    write_cfg(1, 8'hFF, 2, 1, 1);
    cyc();
    start = 2'b10;
    cyc();
    cnt = 0;
    hold = '0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (led[1]) cnt++;
      if (done[1]) hold[0] = 1'b1;
    end
    check("ch1_pwm_quarter_count", cnt, 4);
    check("ch1_no_done", int'(hold[0]), 0);
    stop = 2'b10;
    cyc();
    check("ch1_stop_led", int'(led[1]), 0);
    check("ch1_stop_busy", int'(busy[1]), 0);

    // Config write while running does not disturb the active pattern.
    write_cfg(0, 8'b0000_0001, 2, 1, 3);
    cyc();
    start = 2'b01;
    cyc();
    repeat (6) cyc();
    write_cfg(0, 8'hFF, 2, 1, 3);
    cyc();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (led[0]) cnt++;
    end
    check("ch0_shadow_isolated", cnt, 4);
    start = 2'b01;
    cyc();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (led[0]) cnt++;
    end
    check("ch0_new_pattern_solid", cnt, 12);

    // Start and stop together: stop wins, no done.
    start = 2'b01;
    stop  = 2'b01;
    cyc();
    check("startstop_busy", int'(busy[0]), 0);
    check("startstop_done", int'(done[0]), 0);

    // Start coinciding with a bit step: bit 0 is held a full period.
    write_cfg(0, 8'b0000_0001, 2, 1, 3);
    cyc();
    while ((m_cnt % SD) != SD - 1) cyc();
    start = 2'b01;
    cyc();
    hold[0] = led[0];
    for (int i = 1; i < 8; i++) begin
      cyc();
      hold[i] = led[0];
    end
    check("start_on_tick_hold", int'(hold), 8'b0000_1111);

    // Reset in the middle of looped runs on both channels.
    start = 2'b10;
    cyc();
    repeat (5) cyc();
    check("both_running", int'(busy), 3);
    reset = 1'b1;
    cyc();
    check("midrun_reset_outputs", int'({led, busy, done}), 0);
    reset = 1'b0;
    start = 2'b11;
    cyc();
    check("post_reset_start_ignored", int'(busy), 0);
    repeat (4) begin
      cyc();
      check("post_reset_idle", int'(busy), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0)
        write_cfg(int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 8)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      for (int c = 0; c < CH; c++) begin
        start[c] = ($urandom_range(0, 15) == 0);
        stop[c]  = ($urandom_range(0, 31) == 0);
      end
      cyc();
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
